// File: rtl/opsum_requant_packer.sv
// Requantises signed opsums (bias, rounding shift, ReLU, int8 saturation), re-encodes them
// to offset-128 bytes and packs four bytes per word with valid/ready on both sides.
module opsum_requant_packer #(
    parameter int DATA_BITS  = 32,
    parameter int SHIFT_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_load,
    input  logic [31:0]           cfg_bias,
    input  logic [SHIFT_BITS-1:0] cfg_shift,
    input  logic                  cfg_relu,
    input  logic [DATA_BITS-1:0]  opsum,
    input  logic                  opsum_valid,
    input  logic                  opsum_last,
    output logic                  opsum_ready,
    output logic [DATA_BITS-1:0]  ofmap_data,
    output logic                  ofmap_valid,
    output logic                  ofmap_last,
    input  logic                  ofmap_ready,
    output logic                  busy
);
    localparam int BW = DATA_BITS + 2;
    localparam logic [BW-1:0]         ONE_B      = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [SHIFT_BITS-1:0] SHIFT_ONE  = {{(SHIFT_BITS-1){1'b0}}, 1'b1};
    localparam logic signed [BW-1:0]  SAT_HI     = {{(BW-8){1'b0}}, 8'h7F};
    localparam logic signed [BW-1:0]  SAT_LO     = {{(BW-8){1'b1}}, 8'h80};

    logic [31:0]           cfg_bias_q,  cfg_bias_d;
    logic [SHIFT_BITS-1:0] cfg_shift_q, cfg_shift_d;
    logic                  cfg_relu_q,  cfg_relu_d;
    logic                  s1_valid_q,  s1_valid_d;
    logic [BW-1:0]         s1_b_q,      s1_b_d;
    logic                  s1_last_q,   s1_last_d;
    logic                  s2_valid_q,  s2_valid_d;
    logic [7:0]            s2_byte_q,   s2_byte_d;
    logic                  s2_last_q,   s2_last_d;
    logic [1:0]            pcnt_q,      pcnt_d;
    logic [23:0]           pack_q,      pack_d;
    logic                  ofmap_valid_q, ofmap_valid_d;
    logic [DATA_BITS-1:0]  ofmap_data_q,  ofmap_data_d;
    logic                  ofmap_last_q,  ofmap_last_d;
    logic                  busy_q,        busy_d;

    logic                  completing_s, s1_adv_s, s2_adv_s, in_xfer_s, ofmap_xfer_s;
    logic [BW-1:0]         round_s, b_s;
    logic signed [BW-1:0]  y_s, lo_s, yc_s;
    logic [7:0]            byte_s;
    logic [31:0]           lanes_s, word_s;

    // Handshake chain: a completing byte needs the output register free or draining.
    always_comb begin
        ofmap_xfer_s = ofmap_valid_q & ofmap_ready;
        completing_s = (pcnt_q == 2'd3) | s2_last_q;
        s2_adv_s     = s2_valid_q & (~completing_s | ~ofmap_valid_q | ofmap_ready);
        s1_adv_s     = s1_valid_q & (~s2_valid_q | s2_adv_s);
        opsum_ready  = ~s1_valid_q | s1_adv_s;
        in_xfer_s    = opsum_valid & opsum_ready;
    end

    // Arithmetic: rounding bias, shift, clamp, offset-128 encode, word assembly.
    always_comb begin
        if (cfg_shift_q != {SHIFT_BITS{1'b0}}) begin
            round_s = ONE_B << (cfg_shift_q - SHIFT_ONE);
        end else begin
            round_s = {BW{1'b0}};
        end
        b_s  = {{2{opsum[DATA_BITS-1]}}, opsum}
             + {{(BW-32){cfg_bias_q[31]}}, cfg_bias_q} + round_s;
        y_s  = $signed(s1_b_q) >>> cfg_shift_q;
        lo_s = cfg_relu_q ? {BW{1'b0}} : SAT_LO;
        if (y_s > SAT_HI) begin
            yc_s = SAT_HI;
        end else if (y_s < lo_s) begin
            yc_s = lo_s;
        end else begin
            yc_s = y_s;
        end
        byte_s  = yc_s[7:0] ^ 8'h80;
        lanes_s = {8'h80, pack_q};
        word_s  = 32'h0000_0000;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(pcnt_q)) begin
                word_s[8*k +: 8] = lanes_s[8*k +: 8];
            end else if (k == int'(pcnt_q)) begin
                word_s[8*k +: 8] = s2_byte_q;
            end else begin
                word_s[8*k +: 8] = 8'h80;
            end
        end
    end

    // Next-state for config, pipeline stages, packer and output register.
    always_comb begin
        cfg_bias_d  = cfg_bias_q;
        cfg_shift_d = cfg_shift_q;
        cfg_relu_d  = cfg_relu_q;
        if (cfg_load && !busy_q) begin
            cfg_bias_d  = cfg_bias;
            cfg_shift_d = cfg_shift;
            cfg_relu_d  = cfg_relu;
        end else begin
            cfg_bias_d  = cfg_bias_q;
        end

        s1_valid_d = s1_valid_q;
        s1_b_d     = s1_b_q;
        s1_last_d  = s1_last_q;
        if (in_xfer_s) begin
            s1_valid_d = 1'b1;
            s1_b_d     = b_s;
            s1_last_d  = opsum_last;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        s2_valid_d = s2_valid_q;
        s2_byte_d  = s2_byte_q;
        s2_last_d  = s2_last_q;
        if (s1_adv_s) begin
            s2_valid_d = 1'b1;
            s2_byte_d  = byte_s;
            s2_last_d  = s1_last_q;
        end else if (s2_adv_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end

        pcnt_d        = pcnt_q;
        pack_d        = pack_q;
        ofmap_valid_d = ofmap_valid_q;
        ofmap_data_d  = ofmap_data_q;
        ofmap_last_d  = ofmap_last_q;
        if (s2_adv_s && completing_s) begin
            pcnt_d        = 2'd0;
            pack_d        = 24'h00_0000;
            ofmap_valid_d = 1'b1;
            ofmap_data_d  = word_s;
            ofmap_last_d  = s2_last_q;
        end else begin
            if (s2_adv_s) begin
                for (int k = 0; k < 3; k++) begin
                    if (k == int'(pcnt_q)) begin
                        pack_d[8*k +: 8] = s2_byte_q;
                    end else begin
                        pack_d[8*k +: 8] = pack_q[8*k +: 8];
                    end
                end
                pcnt_d = pcnt_q + 2'd1;
            end else begin
                pcnt_d = pcnt_q;
            end
            if (ofmap_xfer_s) begin
                ofmap_valid_d = 1'b0;
            end else begin
                ofmap_valid_d = ofmap_valid_q;
            end
        end

        busy_d = s1_valid_d | s2_valid_d | (pcnt_d != 2'd0) | ofmap_valid_d;
    end

    // State registers; reset discards any partial pack and restores zero config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_bias_q    <= 32'h0000_0000;
            cfg_shift_q   <= {SHIFT_BITS{1'b0}};
            cfg_relu_q    <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_b_q        <= {BW{1'b0}};
            s1_last_q     <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_byte_q     <= 8'h00;
            s2_last_q     <= 1'b0;
            pcnt_q        <= 2'd0;
            pack_q        <= 24'h00_0000;
            ofmap_valid_q <= 1'b0;
            ofmap_data_q  <= {DATA_BITS{1'b0}};
            ofmap_last_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            cfg_bias_q    <= cfg_bias_d;
            cfg_shift_q   <= cfg_shift_d;
            cfg_relu_q    <= cfg_relu_d;
            s1_valid_q    <= s1_valid_d;
            s1_b_q        <= s1_b_d;
            s1_last_q     <= s1_last_d;
            s2_valid_q    <= s2_valid_d;
            s2_byte_q     <= s2_byte_d;
            s2_last_q     <= s2_last_d;
            pcnt_q        <= pcnt_d;
            pack_q        <= pack_d;
            ofmap_valid_q <= ofmap_valid_d;
            ofmap_data_q  <= ofmap_data_d;
            ofmap_last_q  <= ofmap_last_d;
            busy_q        <= busy_d;
        end
    end

    assign ofmap_valid = ofmap_valid_q;
    assign ofmap_data  = ofmap_data_q;
    assign ofmap_last  = ofmap_last_q;
    assign busy        = busy_q;
endmodule
